// File: rtl/hot_addr_sorted_cam_if.sv
// Readout stream of the hot-address table: one {addr, cnt} beat per handshake.
// master drives rd_valid/rd_addr/rd_cnt/rd_last, slave drives rd_ready.
interface hot_addr_sorted_cam_if #(
    parameter int ADDR_SIZE = 22,
    parameter int CNT_SIZE  = 32
);
    logic                 rd_valid;
    logic                 rd_ready;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [CNT_SIZE-1:0]  rd_cnt;
    logic                 rd_last;

    modport master (
        output rd_valid,
        output rd_addr,
        output rd_cnt,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_addr,
        input  rd_cnt,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/hot_addr_sorted_cam.sv
// Keeps the NUM_ENTRY hottest addresses sorted by descending count, one update per cycle.
// Ports: clk, rst_n, query_rst_n, in_valid/in_addr/in_cnt (update), rd_start, rd (stream), rd_done, busy, occupancy.
module hot_addr_sorted_cam #(
    parameter int NUM_ENTRY = 16,
    parameter int ADDR_SIZE = 22,
    parameter int CNT_SIZE  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             query_rst_n,
    input  logic                             in_valid,
    input  logic [ADDR_SIZE-1:0]             in_addr,
    input  logic [CNT_SIZE-1:0]              in_cnt,
    input  logic                             rd_start,
    hot_addr_sorted_cam_if.master            rd,
    output logic                             rd_done,
    output logic                             busy,
    output logic [$clog2(NUM_ENTRY+1)-1:0]   occupancy
);
    localparam int OW = $clog2(NUM_ENTRY + 1);
    localparam int IW = $clog2(NUM_ENTRY);

    typedef struct packed {
        logic                 v;
        logic [ADDR_SIZE-1:0] addr;
        logic [CNT_SIZE-1:0]  cnt;
    } ent_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

    ent_t                 tab_q [NUM_ENTRY];
    ent_t                 tab_d [NUM_ENTRY];
    ent_t                 tab_sh[NUM_ENTRY];
    logic [OW-1:0]        occ_q;
    logic [OW-1:0]        occ_d;

    logic                 hit;
    logic [IW-1:0]        m;
    logic [OW-1:0]        p;
    logic [IW-1:0]        hi;
    logic                 do_wr;

    logic [ADDR_SIZE-1:0] snap_addr[NUM_ENTRY];
    logic [CNT_SIZE-1:0]  snap_cnt [NUM_ENTRY];
    logic [OW-1:0]        snap_len;
    logic [IW-1:0]        idx;
    logic                 last_beat;
    logic                 start_ok;

    state_t               state_q;
    state_t               state_d;

    // p counts entries with cnt >= in_cnt, which places new or raised
    // counts after equal ones. On a raise the hit entry itself is below
    // in_cnt, so it is never part of p.
    always_comb begin
        hit = 1'b0;
        m   = '0;
        p   = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (tab_q[i].v && tab_q[i].addr == in_addr) begin
                hit = 1'b1;
                m   = IW'(i);
            end
            if (tab_q[i].v && tab_q[i].cnt >= in_cnt) begin
                p = p + OW'(1);
            end
        end
        do_wr = in_valid && query_rst_n && (in_cnt != '0) &&
                (hit ? (in_cnt > tab_q[m].cnt) : (p != OW'(NUM_ENTRY)));
        // Shift window ends at the hit slot, or at the tail on a miss.
        hi = hit ? m : IW'(NUM_ENTRY - 1);
    end

    always_comb begin
        tab_sh[0] = '0;
        for (int i = 1; i < NUM_ENTRY; i++) begin
            tab_sh[i] = tab_q[i-1];
        end
    end

    always_comb begin
        tab_d = tab_q;
        occ_d = occ_q;
        if (do_wr) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                if (OW'(i) == p) begin
                    tab_d[i] = '{v: 1'b1, addr: in_addr, cnt: in_cnt};
                end else if (OW'(i) > p && IW'(i) <= hi) begin
                    tab_d[i] = tab_sh[i];
                end
            end
            if (!hit && occ_q != OW'(NUM_ENTRY)) begin
                occ_d = occ_q + OW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                tab_q[i] <= '0;
            end
            occ_q <= '0;
        end else if (!query_rst_n) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                tab_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            tab_q <= tab_d;
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
    assign last_beat = (OW'(idx) == snap_len - OW'(1));
    assign start_ok  = (state_q == IDLE) && rd_start;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (rd_start) state_d = (occ_q != '0) ? READ : DONE;
            READ: if (rd.rd_ready && last_beat) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!query_rst_n) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                snap_addr[i] <= '0;
                snap_cnt[i]  <= '0;
            end
            snap_len <= '0;
            idx      <= '0;
        end else if (!query_rst_n) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                snap_addr[i] <= '0;
                snap_cnt[i]  <= '0;
            end
            snap_len <= '0;
            idx      <= '0;
        end else if (start_ok) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                snap_addr[i] <= tab_q[i].addr;
                snap_cnt[i]  <= tab_q[i].cnt;
            end
            snap_len <= occ_q;
            idx      <= '0;
        end else if (state_q == READ && rd.rd_ready && !last_beat) begin
            idx <= idx + IW'(1);
        end
    end

    // Status outputs are gated by query_rst_n so an abort is seen at once.
    assign rd.rd_valid = query_rst_n && (state_q == READ);
    assign rd.rd_last  = query_rst_n && (state_q == READ) && last_beat;
    assign rd.rd_addr  = snap_addr[idx];
    assign rd.rd_cnt   = snap_cnt[idx];
    assign rd_done     = query_rst_n && (state_q == DONE);
    assign busy        = query_rst_n && (state_q != IDLE);
endmodule

// File: tb/tb_hot_addr_sorted_cam.sv
// Randomized bench for hot_addr_sorted_cam with a queue-based sorted-table model.
// Drives updates, readouts with varied rd_ready, query resets and aborts.
module tb_hot_addr_sorted_cam;
    localparam int N  = 4;
    localparam int AW = 22;
    localparam int CW = 32;

    typedef struct {
        logic [AW-1:0] a;
        logic [CW-1:0] c;
    } ment_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          query_rst_n;
    logic          in_valid;
    logic [AW-1:0] in_addr;
    logic [CW-1:0] in_cnt;
    logic          rd_start;
    logic          rd_done;
    logic          busy;
    logic [2:0]    occupancy;

    int n_checks = 0;
    int n_errors = 0;

    ment_t q[$];

    hot_addr_sorted_cam_if #(.ADDR_SIZE(AW), .CNT_SIZE(CW)) rd_if ();

    hot_addr_sorted_cam #(
        .NUM_ENTRY(N),
        .ADDR_SIZE(AW),
        .CNT_SIZE(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .query_rst_n(query_rst_n),
        .in_valid   (in_valid),
        .in_addr    (in_addr),
        .in_cnt     (in_cnt),
        .rd_start   (rd_start),
        .rd         (rd_if),
        .rd_done    (rd_done),
        .busy       (busy),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sorted-list semantics: drop, remove-on-raise, insert after equal
    // counts, keep at most N.
    function automatic void model_upd(input logic [AW-1:0] a,
                                      input logic [CW-1:0] c);
        int found;
        int pos;
        ment_t e;
        if (c == 0) return;
        found = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].a == a) found = i;
        end
        if (found >= 0) begin
            if (c <= q[found].c) return;
            q.delete(found);
        end
        pos = 0;
        while (pos < q.size() && q[pos].c >= c) pos++;
        e.a = a;
        e.c = c;
        q.insert(pos, e);
        if (q.size() > N) void'(q.pop_back());
    endfunction

    task automatic cyc();
        if (!query_rst_n) q.delete();
        else if (in_valid) model_upd(in_addr, in_cnt);
        @(posedge clk);
        #1;
        check("occupancy", 64'(occupancy), 64'(q.size()));
    endtask

    task automatic upd(input logic [AW-1:0] a, input logic [CW-1:0] c);
        in_valid = 1'b1;
        in_addr  = a;
        in_cnt   = c;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic rand_upd();
        in_valid = ($urandom % 4) != 0;
        in_addr  = AW'((($urandom % 8) + 1) * 16);
        in_cnt   = CW'($urandom_range(0, 20));
    endtask

    task automatic qreset();
        query_rst_n = 1'b0;
        cyc();
        query_rst_n = 1'b1;
    endtask

    // mode 0: ready toggles 1,0,1..; 1: random; 2: always ready
    task automatic readout(input int mode, input int inj_at,
                           input logic [AW-1:0] ia, input logic [CW-1:0] ic,
                           input bit rnd);
        ment_t exp[$];
        int k;
        int t;
        exp = q;
        rd_start = 1'b1;
        if (rnd) rand_upd();
        else in_valid = 1'b0;
        cyc();
        rd_start = 1'b0;
        in_valid = 1'b0;
        k = 0;
        t = 0;
        while (k < exp.size() && t < 200) begin
            check("rd_valid", 64'(rd_if.rd_valid), 64'(1));
            check("busy_read", 64'(busy), 64'(1));
            case (mode)
                0: rd_if.rd_ready = (t % 2) == 0;
                1: rd_if.rd_ready = ($urandom % 2) != 0;
                default: rd_if.rd_ready = 1'b1;
            endcase
            check("rd_addr", 64'(rd_if.rd_addr), 64'(exp[k].a));
            check("rd_cnt", 64'(rd_if.rd_cnt), 64'(exp[k].c));
            check("rd_last", 64'(rd_if.rd_last), 64'(k == exp.size() - 1));
            if (rd_if.rd_ready) k++;
            if (t == inj_at) begin
                in_valid = 1'b1;
                in_addr  = ia;
                in_cnt   = ic;
            end else if (rnd) begin
                rand_upd();
            end else begin
                in_valid = 1'b0;
            end
            rd_start = rnd && (($urandom % 4) == 0);
            cyc();
            t++;
        end
        rd_start = 1'b0;
        in_valid = 1'b0;
        if (k < exp.size()) check("rd_timeout", 64'(k), 64'(exp.size()));
        check("done_valid", 64'(rd_if.rd_valid), 64'(0));
        check("rd_done", 64'(rd_done), 64'(1));
        check("busy_done", 64'(busy), 64'(1));
        cyc();
        check("done_clr", 64'(rd_done), 64'(0));
        check("busy_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        query_rst_n    = 1'b1;
        in_valid       = 1'b0;
        in_addr        = '0;
        in_cnt         = '0;
        rd_start       = 1'b0;
        rd_if.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_occ", 64'(occupancy), 64'(0));
        check("rst_valid", 64'(rd_if.rd_valid), 64'(0));
        check("rst_addr", 64'(rd_if.rd_addr), 64'(0));
        check("rst_cnt", 64'(rd_if.rd_cnt), 64'(0));
        check("rst_last", 64'(rd_if.rd_last), 64'(0));
        check("rst_done", 64'(rd_done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        cyc();

        upd(22'h10, 5);
        upd(22'h20, 9);
        upd(22'h30, 7);
        readout(2, -1, '0, '0, 0);
        upd(22'h40, 1);
        upd(22'h50, 6);
        readout(2, -1, '0, '0, 0);
        upd(22'h60, 5);
        readout(2, -1, '0, '0, 0);
        upd(22'h10, 8);
        upd(22'h10, 3);
        upd(22'h70, 0);
        readout(0, 2, 22'h30, 20, 0);
        readout(2, -1, '0, '0, 0);

        qreset();
        readout(2, -1, '0, '0, 0);

        upd(22'h10, 4);
        upd(22'h20, 4);
        upd(22'h30, 4);
        rd_start = 1'b1;
        cyc();
        rd_start       = 1'b0;
        rd_if.rd_ready = 1'b1;
        cyc();
        query_rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(rd_if.rd_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_last", 64'(rd_if.rd_last), 64'(0));
        cyc();
        query_rst_n = 1'b1;
        check("abort_done", 64'(rd_done), 64'(0));
        check("abort_busy2", 64'(busy), 64'(0));
        check("abort_valid2", 64'(rd_if.rd_valid), 64'(0));
        readout(2, -1, '0, '0, 0);

        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(3, 15)) begin
                rand_upd();
                cyc();
            end
            in_valid = 1'b0;
            if (($urandom % 6) == 0) qreset();
            else readout(1, -1, '0, '0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hot_addr_sorted_cam.md
# hot_addr_sorted_cam

Consumer of the sketch min-estimate stream: takes one (address, min count) pair per cycle from the min-computation pipeline and keeps a table of the NUM_ENTRY hottest addresses, sorted by count in descending order. Each update is applied in a single cycle, so the block never backpressures the upstream pipeline. Host/migration logic reads the table through a snapshot-based valid/ready stream. A query reset clears the table and aborts any readout.

## Interface
- NUM_ENTRY, 16, table depth; must be ≥2.
- ADDR_SIZE, 22, address width.
- CNT_SIZE, 32, count width.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- query_rst_n  in  1  synchronous active-low clear of table and readout.
- in_valid  in  1  update strobe; no ready, so every strobe must be accepted.
- in_addr  in  ADDR_SIZE  address of the update.
- in_cnt  in  CNT_SIZE  min-count estimate for in_addr.
- rd_start  in  1  readout request pulse.
- rd_ready  in  1  sink ready.
- rd_valid  out  1  readout beat valid.
- rd_addr  out  ADDR_SIZE  beat address.
- rd_cnt  out  CNT_SIZE  beat count.
- rd_last  out  1  final beat of a readout.
- rd_done  out  1  one-cycle pulse when a readout completes.
- busy  out  1  readout in progress (state ≠ IDLE).
- occupancy  out  $clog2(NUM_ENTRY+1)  number of valid table entries.

## Operation
- Table layout: entries 0..NUM_ENTRY-1, each holding {v, addr, cnt}.
  - Valid entries are contiguous from index 0.
  - cnt is non-increasing with index.
- Ignored updates: in_valid with in_cnt==0, or any input while query_rst_n is low.
- Match case: a valid entry m has addr == in_addr.
  - If in_cnt ≤ cnt[m], no change.
  - Otherwise p = number of valid entries other than m with cnt ≥ in_cnt (p ≤ m).
  - Entries p..m-1 move to p+1..m, and entry p becomes {1, in_addr, in_cnt}.
- Miss case: p = number of valid entries with cnt ≥ in_cnt.
  - If p == NUM_ENTRY, the update is dropped.
  - Otherwise entries p..NUM_ENTRY-2 shift down by one, entry NUM_ENTRY-1 is evicted, and entry p is written.
  - occupancy increments only if it was below NUM_ENTRY.
- Ties: a new or raised count is placed after existing equal counts.
- Addresses are unique in the table at all times.
- Readout FSM states: IDLE, READ, DONE.
  - IDLE + rd_start: copy the table (pre-edge contents) into snapshot registers and latch the snapshot length n = occupancy. Go to READ if n > 0, else DONE. rd_start outside IDLE is ignored.
  - READ: present snapshot[idx] with rd_valid=1, rd_last=(idx==n-1). On rd_valid&rd_ready, idx advances. On the last beat's handshake, go to DONE.
  - DONE: rd_done=1 for exactly one cycle, then IDLE.
- Table updates continue during READ; they never alter the snapshot stream.
- query_rst_n low: clears every table entry, occupancy, snapshot, idx and the FSM (to IDLE) at the next edge, and no rd_done is issued.
  - While query_rst_n is low, rd_valid, rd_last, rd_done and busy are forced to 0 combinationally.

## Timing
- Reset values (rst_n low): all table/snapshot entries invalid and zero, occupancy 0, rd_valid 0, rd_addr 0, rd_cnt 0, rd_last 0, rd_done 0, busy 0, FSM IDLE.
- Update applied at the edge where in_valid is sampled; visible in table/occupancy the cycle after. Back-to-back updates, including same address, are applied in order.
- rd_start sampled at edge T: rd_valid high from T+1 (n > 0). For n == 0, rd_done high during T+1.
- One beat per cycle at full rate while rd_ready is held. rd_addr, rd_cnt and rd_last are stable while rd_valid&!rd_ready.
- Last handshake at edge E: rd_valid low and rd_done high during E+1; IDLE at E+2, when a new rd_start is accepted.
- Snapshot taken in the same cycle as an update captures the pre-update table.

## Test plan
- NUM_ENTRY=4 for all scenarios.
- Insert (0x10,5), (0x20,9), (0x30,7) → table 0x20/9, 0x30/7, 0x10/5; occupancy 3.
- Then (0x40,1), then (0x50,6) → 0x20/9, 0x30/7, 0x50/6, 0x10/5 (0x40 evicted); then (0x60,5) dropped and the table is unchanged.
- Match: (0x10,8) → 0x20/9, 0x10/8, 0x30/7, 0x50/6. Then (0x10,3) → no change. Then (0x70,0) → ignored.
- Readout: rd_start with rd_ready toggling 1,0,1,0… → four beats in table order, with rd_last on the 4th only. Fields hold while stalled, and rd_done pulses one cycle after the last handshake. An update of (0x30,20) injected mid-read does not change the streamed values.
- Empty readout after query reset: rd_start at T → no rd_valid, rd_done=1 at T+1, busy 0 at T+2.
- Abort: pull query_rst_n low for 1 cycle during the second beat → rd_valid/busy drop immediately, no rd_done, occupancy 0 afterward, and the next rd_start yields the empty-readout behaviour.
